// File: rtl/posit_extract_if.sv
// Stream bundle for the posit decoder: raw word in, unpacked fields out.
// The slave modport is the decoder's view and master is the upstream/downstream side.
interface posit_extract_if #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int FBITS = NBITS - 3 - ES
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [6:0]       out_scale;
  logic [ES-1:0]    out_exponent;
  logic [FBITS-1:0] out_fraction;
  logic             out_inf;
  logic             out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_scale, out_exponent,
           out_fraction, out_inf, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_scale, out_exponent,
           out_fraction, out_inf, out_zero
  );
endinterface

// File: rtl/posit_extract.sv
// Two-stage posit decoder: S1 takes |x| and the regime run length, S2 emits k/exponent/fraction.
// Define POSIT_EXTRACT_STATS_EN to add saturating NaR/zero transfer counters.
module posit_extract #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int FBITS = NBITS - 3 - ES
) (
  input  logic        clk,
  input  logic        rst_n,
  posit_extract_if.slave bus
`ifdef POSIT_EXTRACT_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_nar_cnt,
  output logic [15:0] stat_zero_cnt
`endif
);
  localparam int MW   = NBITS - 1;
  localparam int RW   = $clog2(NBITS);
  localparam int DROP = MW - ES - FBITS;

  logic          s1_valid, s2_valid, s1_ready, s2_ready;
  logic          s1_sign, s1_zero, s1_inf;
  logic [MW-1:0] s1_mag;
  logic [RW-1:0] s1_run;

  logic [MW-1:0]       mag;
  logic [RW-1:0]       run;
  logic                run_done;
  logic [RW:0]         shamt;
  logic [ES+FBITS-1:0] body;
  logic [6:0]          k;

  assign s2_ready      = !s2_valid || bus.out_ready;
  assign s1_ready      = !s1_valid || s2_ready;
  assign bus.in_ready  = s1_ready;
  assign bus.out_valid = s2_valid;

  always_comb begin
    mag      = MW'(bus.in_data[NBITS-1] ? (~bus.in_data + 1'b1) : bus.in_data);
    run      = '0;
    run_done = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!run_done) begin
        if (mag[i] == mag[MW-1]) run = run + 1'b1;
        else run_done = 1'b1;
      end
    end
  end

  // Shifting past the run and terminator; an all-ones/all-zeros run shifts everything out.
  always_comb begin
    shamt = {1'b0, s1_run} + 1'b1;
    body  = (ES+FBITS)'((s1_mag << shamt) >> DROP);
    k     = s1_mag[MW-1] ? (7'(s1_run) - 7'd1) : (7'd0 - 7'(s1_run));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid         <= 1'b0;
      s1_sign          <= 1'b0;
      s1_zero          <= 1'b0;
      s1_inf           <= 1'b0;
      s1_mag           <= '0;
      s1_run           <= '0;
      s2_valid         <= 1'b0;
      bus.out_sign     <= 1'b0;
      bus.out_scale    <= '0;
      bus.out_exponent <= '0;
      bus.out_fraction <= '0;
      bus.out_inf      <= 1'b0;
      bus.out_zero     <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sign <= bus.in_data[NBITS-1];
          s1_zero <= (bus.in_data == '0);
          s1_inf  <= (bus.in_data == {1'b1, {MW{1'b0}}});
          s1_mag  <= mag;
          s1_run  <= run;
        end
      end
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_sign <= s1_sign;
          bus.out_inf  <= s1_inf;
          bus.out_zero <= s1_zero;
          if (s1_zero || s1_inf) begin
            bus.out_scale    <= '0;
            bus.out_exponent <= '0;
            bus.out_fraction <= '0;
          end else begin
            bus.out_scale    <= k;
            bus.out_exponent <= body[ES+FBITS-1 -: ES];
            bus.out_fraction <= body[FBITS-1:0];
          end
        end
      end
    end
  end

`ifdef POSIT_EXTRACT_STATS_EN
  logic out_fire;
  assign out_fire = s2_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_nar_cnt  <= '0;
      stat_zero_cnt <= '0;
    end else if (stat_clr) begin
      stat_nar_cnt  <= '0;
      stat_zero_cnt <= '0;
    end else if (out_fire) begin
      if (bus.out_inf && stat_nar_cnt != 16'hFFFF) stat_nar_cnt <= stat_nar_cnt + 16'd1;
      if (bus.out_zero && stat_zero_cnt != 16'hFFFF) stat_zero_cnt <= stat_zero_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_posit_extract.sv
// Scoreboard bench for posit_extract: driver queues hand-computed results, monitor pops on output transfers.
module tb_posit_extract;
  localparam int NBITS = 32;
  localparam int ES    = 2;
  localparam int FBITS = 27;
  localparam int NV    = 14;

  typedef struct packed {
    logic             sign;
    logic [6:0]       scale;
    logic [ES-1:0]    expo;
    logic [FBITS-1:0] frac;
    logic             inf;
    logic             zero;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  posit_extract_if #(.NBITS(NBITS), .ES(ES), .FBITS(FBITS)) pif ();

`ifdef POSIT_EXTRACT_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_nar_cnt, stat_zero_cnt;
`endif

  posit_extract #(.NBITS(NBITS), .ES(ES), .FBITS(FBITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pif)
`ifdef POSIT_EXTRACT_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_nar_cnt  (stat_nar_cnt),
    .stat_zero_cnt (stat_zero_cnt)
`endif
  );

  res_t act;
  assign act = {pif.out_sign, pif.out_scale, pif.out_exponent, pif.out_fraction,
                pif.out_inf, pif.out_zero};

  res_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int n_in  = 0;
  int n_out = 0;

  logic [31:0] vw[NV];
  res_t        vr[NV];

  function automatic res_t mk(input logic s, input logic [6:0] sc, input logic [1:0] e,
                              input logic [26:0] f, input logic inf, input logic z);
    mk = {s, sc, e, f, inf, z};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic send(input logic [31:0] w, input res_t e);
    int g;
    bit ok;
    g  = 0;
    ok = 1'b1;
    @(negedge clk);
    pif.in_valid = 1'b1;
    pif.in_data  = w;
    #1;
    while (!pif.in_ready && ok) begin
      g++;
      if (g > 40) begin
        total++;
        bad++;
        $display("FAIL send timeout: in_ready stuck at %0b for word %h", pif.in_ready, w);
        ok = 1'b0;
      end else begin
        @(negedge clk);
        #1;
      end
    end
    if (ok) begin
      @(posedge clk);
      exp_q.push_back(e);
      n_in++;
    end else begin
      pif.in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    pif.in_valid = 1'b0;
    pif.in_data  = '0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    #3;
    chk("drain pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: checks each output transfer against the queue and holds during stalls.
  res_t held;
  bit   stalled = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        chk("stall valid", 64'(pif.out_valid), 64'd1);
        chk("stall hold", 64'(act), 64'(held));
      end
      stalled = 1'b0;
      if (pif.out_valid) begin
        if (pif.out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected output: got %h expected none", act);
          end else begin
            chk("decode", 64'(act), 64'(exp_q.pop_front()));
          end
        end else begin
          stalled = 1'b1;
          held    = act;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n_before;
    vw[0]  = 32'h40000000; vr[0]  = mk(0, 7'd0,  2'd0, 27'd0,        0, 0);
    vw[1]  = 32'h48000000; vr[1]  = mk(0, 7'd0,  2'd1, 27'd0,        0, 0);
    vw[2]  = 32'hC0000000; vr[2]  = mk(1, 7'd0,  2'd0, 27'd0,        0, 0);
    vw[3]  = 32'h7FFFFFFF; vr[3]  = mk(0, 7'd30, 2'd0, 27'd0,        0, 0);
    vw[4]  = 32'h00000001; vr[4]  = mk(0, 7'h62, 2'd0, 27'd0,        0, 0);
    vw[5]  = 32'h00000000; vr[5]  = mk(0, 7'd0,  2'd0, 27'd0,        0, 1);
    vw[6]  = 32'h80000000; vr[6]  = mk(1, 7'd0,  2'd0, 27'd0,        1, 0);
    vw[7]  = 32'h40000001; vr[7]  = mk(0, 7'd0,  2'd0, 27'd1,        0, 0);
    vw[8]  = 32'h3FFFFFFF; vr[8]  = mk(0, 7'h7F, 2'd3, 27'h7FFFFFF,  0, 0);
    vw[9]  = 32'h7A000000; vr[9]  = mk(0, 7'd3,  2'd2, 27'd0,        0, 0);
    vw[10] = 32'h0C800000; vr[10] = mk(0, 7'h7D, 2'd2, 27'h2000000,  0, 0);
    vw[11] = 32'hBFFFFFFF; vr[11] = mk(1, 7'd0,  2'd0, 27'd1,        0, 0);
    vw[12] = 32'hFFFFFFFF; vr[12] = mk(1, 7'h62, 2'd0, 27'd0,        0, 0);
    vw[13] = 32'h80000001; vr[13] = mk(1, 7'd30, 2'd0, 27'd0,        0, 0);

    pif.in_valid  = 1'b0;
    pif.in_data   = '0;
    pif.out_ready = 1'b1;
    rst_n         = 1'b0;
    #12;
    chk("reset out_valid", 64'(pif.out_valid), 64'd0);
    chk("reset fields", 64'(act), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready", 64'(pif.in_ready), 64'd1);

    // Single words with gaps, then the whole table back to back.
    for (int i = 0; i < 4; i++) begin
      send(vw[i], vr[i]);
      idle();
      drain();
    end
    for (int i = 0; i < NV; i++) send(vw[i], vr[i]);
    idle();
    drain();

    // Back-pressure: stall 4 cycles at the first output of a 4-word burst.
    fork
      begin
        for (int i = 0; i < 4; i++) send(vw[i], vr[i]);
        idle();
      end
      begin
        int g;
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!pif.out_valid && g < 20);
        chk("first output seen", 64'(pif.out_valid), 64'd1);
        pif.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("in_ready stalled", 64'(pif.in_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        pif.out_ready = 1'b1;
      end
    join
    drain();
    chk("in/out count", 64'(n_out), 64'(n_in));

    // Reset with two words in flight.
    send(vw[1], vr[1]);
    send(vw[9], vr[9]);
    #1;
    rst_n        = 1'b0;
    pif.in_valid = 1'b0;
    exp_q.delete();
    n_before = n_out;
    #1;
    chk("midreset out_valid", 64'(pif.out_valid), 64'd0);
    chk("midreset fields", 64'(act), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    chk("no stale output", 64'(n_out), 64'(n_before));
    send(vw[10], vr[10]);
    idle();
    drain();

`ifdef POSIT_EXTRACT_STATS_EN
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    send(vw[6], vr[6]);
    send(vw[5], vr[5]);
    send(vw[6], vr[6]);
    send(vw[0], vr[0]);
    send(vw[5], vr[5]);
    send(vw[6], vr[6]);
    idle();
    drain();
    @(posedge clk);
    #1;
    chk("nar count", 64'(stat_nar_cnt), 64'd3);
    chk("zero count", 64'(stat_zero_cnt), 64'd2);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    chk("nar cleared", 64'(stat_nar_cnt), 64'd0);
    chk("zero cleared", 64'(stat_zero_cnt), 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
